reservation_station_nx_fwd: RTL and testbench

//  ENTRIES-deep reservation station for one functional unit, between decode/ROB-read and execute.

---
 rtl/rs_pkg.sv | 60 ++++++
 rtl/rs_entry.sv | 65 ++++++
 rtl/reservation_station_nx_fwd.sv | 193 +++++++++++++++++++
 tb/tb_reservation_station_nx_fwd.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared types and helpers for the reservation station: operand/entry structs,
// broadcast bus bundle, the "no tag" constant and the broadcast capture rules.
package rs_pkg;

  localparam int unsigned RS_ROB_SIZE = 8;
  localparam int unsigned RS_TAG_W    = $clog2(RS_ROB_SIZE + 1);
  localparam int unsigned RS_DATA_W   = 64;
  localparam int unsigned RS_CMD_W    = 10;

  localparam logic [RS_TAG_W-1:0] NO_TAG = '0;

  typedef struct packed {
    logic                 rdy;
    logic [RS_DATA_W-1:0] value;
    logic [RS_TAG_W-1:0]  src_tag;
  } operand_t;

  typedef struct packed {
    operand_t            op1;
    operand_t            op2;
    logic [RS_CMD_W-1:0] cmd;
    logic [RS_TAG_W-1:0] dst_tag;
  } rs_entry_t;

  typedef struct packed {
    logic [RS_TAG_W-1:0] tag;
    logic [RS_DATA_W:0]  val;
  } bcast_t;

  // A broadcast matches a waiting operand when the bus is valid and the tag is real and equal.
  function automatic logic bcast_hit(input logic [RS_TAG_W-1:0] tag,
                                     input logic [RS_DATA_W:0]  val,
                                     input logic [RS_TAG_W-1:0] src_tag);
    return val[RS_DATA_W] && (tag != NO_TAG) && (tag == src_tag);
  endfunction

  // Resolve a waiting operand against the buses; commit beats memory beats execute.
  function automatic operand_t capture(input operand_t op,
                                       input bcast_t   com,
                                       input bcast_t   mem,
                                       input bcast_t   exe,
                                       input logic     exe_en);
    operand_t r;
    r = op;
    if (!op.rdy) begin
      if (bcast_hit(com.tag, com.val, op.src_tag)) begin
        r.rdy   = 1'b1;
        r.value = com.val[RS_DATA_W-1:0];
      end else if (bcast_hit(mem.tag, mem.val, op.src_tag)) begin
        r.rdy   = 1'b1;
        r.value = mem.val[RS_DATA_W-1:0];
      end else if (exe_en && bcast_hit(exe.tag, exe.val, op.src_tag)) begin
        r.rdy   = 1'b1;
        r.value = exe.val[RS_DATA_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: busy flag, stored operands/command and
// per-cycle capture of broadcast results into waiting operands.
module rs_entry
  import rs_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 alloc_i,
  input  logic                 free_i,
  input  rs_entry_t            wr_entry_i,
  input  bcast_t               com_i,
  input  bcast_t               mem_i,
  input  bcast_t               exe_i,
  input  logic                 exe_en_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [RS_DATA_W-1:0] val1_o,
  output logic [RS_DATA_W-1:0] val2_o,
  output logic [RS_CMD_W-1:0]  cmd_o,
  output logic [RS_TAG_W-1:0]  tag_o
);

  logic      busy_q, busy_d;
  rs_entry_t entry_q, entry_d;

  // Next state: capture on held operands, then free, then allocate (with capture at write), flush last.
  always_comb begin
    busy_d      = busy_q;
    entry_d     = entry_q;
    entry_d.op1 = capture(entry_q.op1, com_i, mem_i, exe_i, exe_en_i);
    entry_d.op2 = capture(entry_q.op2, com_i, mem_i, exe_i, exe_en_i);
    if (free_i) begin
      busy_d = 1'b0;
    end
    if (alloc_i) begin
      busy_d      = 1'b1;
      entry_d     = wr_entry_i;
      entry_d.op1 = capture(wr_entry_i.op1, com_i, mem_i, exe_i, exe_en_i);
      entry_d.op2 = capture(wr_entry_i.op2, com_i, mem_i, exe_i, exe_en_i);
    end
    if (flush_i) begin
      busy_d = 1'b0;
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      busy_q  <= busy_d;
      entry_q <= entry_d;
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = busy_q & entry_q.op1.rdy & entry_q.op2.rdy;
  assign val1_o  = entry_q.op1.value;
  assign val2_o  = entry_q.op2.value;
  assign cmd_o   = entry_q.cmd;
  assign tag_o   = entry_q.dst_tag;

endmodule

// File: rtl/reservation_station_nx_fwd.sv
// Reservation station for one functional unit: lowest-free allocation,
// one issue per cycle, broadcast forwarding, flush.
// Build option: RS_AGE_ORDER_EN selects oldest-first issue through an age
// matrix; otherwise the lowest-index ready entry issues.
module reservation_station_nx_fwd
  import rs_pkg::*;
#(
  parameter int unsigned ENTRIES  = 4,
  parameter int unsigned ROB_SIZE = RS_ROB_SIZE,
  parameter int unsigned TAG_W    = $clog2(ROB_SIZE + 1),
  parameter int unsigned DATA_W   = RS_DATA_W,
  parameter int unsigned CMD_W    = RS_CMD_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              dec_we_i,
  input  logic [TAG_W-1:0]  dec_tag_i,
  input  logic [TAG_W-1:0]  dec_src_tag1_i,
  input  logic [TAG_W-1:0]  dec_src_tag2_i,
  input  logic [DATA_W:0]   dec_op1_i,
  input  logic [DATA_W:0]   dec_op2_i,
  input  logic [CMD_W-1:0]  dec_cmd_i,
  output logic              stall_o,
  input  logic [TAG_W-1:0]  com_tag_i,
  input  logic [DATA_W:0]   com_val_i,
  input  logic [TAG_W-1:0]  exe_tag_i,
  input  logic [DATA_W:0]   exe_val_i,
  input  logic              exe_mem_access_i,
  input  logic [TAG_W-1:0]  mem_tag_i,
  input  logic [DATA_W:0]   mem_val_i,
  input  logic              stall_i,
  output logic [DATA_W-1:0] rs_val1_o,
  output logic [DATA_W-1:0] rs_val2_o,
  output logic [CMD_W-1:0]  rs_cmd_o,
  output logic [TAG_W-1:0]  rs_tag_o,
  output logic              ready_o
);

  logic [ENTRIES-1:0] busy, rdy, alloc_oh, free_oh, pick_oh, sel_oh;
  logic [DATA_W-1:0]  e_val1 [ENTRIES];
  logic [DATA_W-1:0]  e_val2 [ENTRIES];
  logic [CMD_W-1:0]   e_cmd  [ENTRIES];
  logic [TAG_W-1:0]   e_tag  [ENTRIES];
  logic               hold_vld_q, hold_vld_d;
  logic [ENTRIES-1:0] hold_oh_q, hold_oh_d;
  rs_entry_t          wr_entry;
  bcast_t             com_b, mem_b, exe_b;

  assign com_b = '{tag: com_tag_i, val: com_val_i};
  assign mem_b = '{tag: mem_tag_i, val: mem_val_i};
  assign exe_b = '{tag: exe_tag_i, val: exe_val_i};

  assign wr_entry = '{op1:     '{rdy: dec_op1_i[DATA_W], value: dec_op1_i[DATA_W-1:0], src_tag: dec_src_tag1_i},
                      op2:     '{rdy: dec_op2_i[DATA_W], value: dec_op2_i[DATA_W-1:0], src_tag: dec_src_tag2_i},
                      cmd:     dec_cmd_i,
                      dst_tag: dec_tag_i};

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    rs_entry u_entry (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .flush_i    (flush_i),
      .alloc_i    (alloc_oh[g]),
      .free_i     (free_oh[g]),
      .wr_entry_i (wr_entry),
      .com_i      (com_b),
      .mem_i      (mem_b),
      .exe_i      (exe_b),
      .exe_en_i   (~exe_mem_access_i),
      .busy_o     (busy[g]),
      .ready_o    (rdy[g]),
      .val1_o     (e_val1[g]),
      .val2_o     (e_val2[g]),
      .cmd_o      (e_cmd[g]),
      .tag_o      (e_tag[g])
    );
  end

  assign stall_o = &busy;
  assign ready_o = |rdy;

  // Free-slot encoder: lowest-index idle entry takes an accepted decode write.
  always_comb begin
    alloc_oh = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!busy[i] && (alloc_oh == '0)) begin
        alloc_oh[i] = 1'b1;
      end
    end
    if (!(dec_we_i && !stall_o && !flush_i)) begin
      alloc_oh = '0;
    end
  end

`ifdef RS_AGE_ORDER_EN
  // Row i holds the entries that were already busy when i was allocated (older than i).
  logic [ENTRIES-1:0] age_q [ENTRIES];
  logic [ENTRIES-1:0] age_d [ENTRIES];

  // Oldest-first pick: ready with no older ready entry.
  always_comb begin
    pick_oh = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      pick_oh[i] = rdy[i] & ~|(age_q[i] & rdy);
    end
  end

  // Age matrix update: a freed entry leaves every row and column; a new entry records who is older.
  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      age_d[i] = age_q[i];
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (free_oh[i]) begin
        age_d[i] = '0;
        for (int unsigned j = 0; j < ENTRIES; j++) begin
          age_d[j][i] = 1'b0;
        end
      end
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (alloc_oh[i]) begin
        age_d[i] = busy & ~free_oh;
      end
    end
    if (flush_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        age_d[i] = '0;
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end
`else
  // Fixed-priority pick: lowest-index ready entry.
  always_comb begin
    pick_oh = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (rdy[i] && (pick_oh == '0)) begin
        pick_oh[i] = 1'b1;
      end
    end
  end
`endif

  // A stalled issue pins its entry so a newly ready entry cannot steal the output mid-stall.
  always_comb begin
    sel_oh     = hold_vld_q ? hold_oh_q : pick_oh;
    free_oh    = (ready_o && !stall_i) ? sel_oh : '0;
    hold_vld_d = ready_o & stall_i & ~flush_i;
    hold_oh_d  = sel_oh;
  end

  // Issue-hold register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      hold_vld_q <= 1'b0;
      hold_oh_q  <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_oh_q  <= hold_oh_d;
    end
  end

  // Output mux: one-hot OR of the selected entry, all zero when nothing issues.
  always_comb begin
    rs_val1_o = '0;
    rs_val2_o = '0;
    rs_cmd_o  = '0;
    rs_tag_o  = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (sel_oh[i]) begin
        rs_val1_o = rs_val1_o | e_val1[i];
        rs_val2_o = rs_val2_o | e_val2[i];
        rs_cmd_o  = rs_cmd_o  | e_cmd[i];
        rs_tag_o  = rs_tag_o  | e_tag[i];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station_nx_fwd.sv
// Self-checking bench for reservation_station_nx_fwd: directed scenarios plus
// randomized traffic against a behavioural model kept here.
module tb_reservation_station_nx_fwd;

  localparam int NE = 4;

  logic        clk_i = 1'b0;
  logic        reset_i, flush_i, dec_we_i, stall_o, exe_mem_access_i, stall_i, ready_o;
  logic [3:0]  dec_tag_i, dec_src_tag1_i, dec_src_tag2_i, com_tag_i, exe_tag_i, mem_tag_i, rs_tag_o;
  logic [64:0] dec_op1_i, dec_op2_i, com_val_i, exe_val_i, mem_val_i;
  logic [9:0]  dec_cmd_i, rs_cmd_o;
  logic [63:0] rs_val1_o, rs_val2_o;

  always #5 clk_i = ~clk_i;

  reservation_station_nx_fwd dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .dec_we_i(dec_we_i),
    .dec_tag_i(dec_tag_i), .dec_src_tag1_i(dec_src_tag1_i), .dec_src_tag2_i(dec_src_tag2_i),
    .dec_op1_i(dec_op1_i), .dec_op2_i(dec_op2_i), .dec_cmd_i(dec_cmd_i), .stall_o(stall_o),
    .com_tag_i(com_tag_i), .com_val_i(com_val_i), .exe_tag_i(exe_tag_i), .exe_val_i(exe_val_i),
    .exe_mem_access_i(exe_mem_access_i), .mem_tag_i(mem_tag_i), .mem_val_i(mem_val_i),
    .stall_i(stall_i), .rs_val1_o(rs_val1_o), .rs_val2_o(rs_val2_o), .rs_cmd_o(rs_cmd_o),
    .rs_tag_o(rs_tag_o), .ready_o(ready_o)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model: slots with allocation sequence numbers for age order.
  typedef struct {
    bit          busy;
    bit          r1, r2;
    logic [63:0] v1, v2;
    logic [3:0]  t1, t2;
    logic [9:0]  cmd;
    logic [3:0]  dst;
    int          seq;
  } ment_t;

  ment_t m [NE];
  int    hold;
  int    seqc;

  function automatic bit m_full();
    for (int i = 0; i < NE; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_sel();
    int best;
    if (hold >= 0) return hold;
    best = -1;
    for (int i = 0; i < NE; i++) begin
      if (m[i].busy && m[i].r1 && m[i].r2) begin
`ifdef RS_AGE_ORDER_EN
        if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  function automatic logic [64:0] m_cap(input bit r, input logic [63:0] v, input logic [3:0] t);
    if (r) return {1'b1, v};
    if (com_val_i[64] && t != 0 && t == com_tag_i) return {1'b1, com_val_i[63:0]};
    if (mem_val_i[64] && t != 0 && t == mem_tag_i) return {1'b1, mem_val_i[63:0]};
    if (!exe_mem_access_i && exe_val_i[64] && t != 0 && t == exe_tag_i) return {1'b1, exe_val_i[63:0]};
    return {1'b0, v};
  endfunction

  function automatic void m_update(input int s);
    int          a;
    logic [64:0] c;
    if (flush_i) begin
      for (int i = 0; i < NE; i++) m[i].busy = 1'b0;
      hold = -1;
      return;
    end
    a = -1;
    if (dec_we_i && !m_full())
      for (int i = 0; i < NE; i++) if (!m[i].busy && a < 0) a = i;
    for (int i = 0; i < NE; i++) begin
      if (m[i].busy) begin
        c = m_cap(m[i].r1, m[i].v1, m[i].t1); m[i].r1 = c[64]; m[i].v1 = c[63:0];
        c = m_cap(m[i].r2, m[i].v2, m[i].t2); m[i].r2 = c[64]; m[i].v2 = c[63:0];
      end
    end
    if (s >= 0 && !stall_i) m[s].busy = 1'b0;
    hold = (s >= 0 && stall_i) ? s : -1;
    if (a >= 0) begin
      m[a].busy = 1'b1;
      c = m_cap(dec_op1_i[64], dec_op1_i[63:0], dec_src_tag1_i); m[a].r1 = c[64]; m[a].v1 = c[63:0];
      c = m_cap(dec_op2_i[64], dec_op2_i[63:0], dec_src_tag2_i); m[a].r2 = c[64]; m[a].v2 = c[63:0];
      m[a].t1 = dec_src_tag1_i; m[a].t2 = dec_src_tag2_i;
      m[a].cmd = dec_cmd_i; m[a].dst = dec_tag_i; m[a].seq = seqc;
      seqc++;
    end
  endfunction

  // Compare all outputs with the model, advance one clock, update the model.
  task automatic tick();
    int s;
    s = m_sel();
    chk("ready_o", 64'(ready_o), 64'(s >= 0));
    chk("stall_o", 64'(stall_o), 64'(m_full()));
    chk("rs_val1_o", rs_val1_o, (s >= 0) ? m[s].v1 : 64'h0);
    chk("rs_val2_o", rs_val2_o, (s >= 0) ? m[s].v2 : 64'h0);
    chk("rs_cmd_o", 64'(rs_cmd_o), (s >= 0) ? 64'(m[s].cmd) : 64'h0);
    chk("rs_tag_o", 64'(rs_tag_o), (s >= 0) ? 64'(m[s].dst) : 64'h0);
    @(posedge clk_i);
    m_update(s);
    @(negedge clk_i);
  endtask

  task automatic idle();
    flush_i = 0; dec_we_i = 0; dec_tag_i = 0; dec_src_tag1_i = 0; dec_src_tag2_i = 0;
    dec_op1_i = '0; dec_op2_i = '0; dec_cmd_i = 0; com_tag_i = 0; com_val_i = '0;
    exe_tag_i = 0; exe_val_i = '0; exe_mem_access_i = 0; mem_tag_i = 0; mem_val_i = '0;
    stall_i = 0;
  endtask

  task automatic write(input logic [3:0] tag, input logic [64:0] op1, input logic [3:0] s1,
                       input logic [64:0] op2, input logic [3:0] s2, input logic [9:0] cmd);
    dec_we_i = 1; dec_tag_i = tag; dec_op1_i = op1; dec_src_tag1_i = s1;
    dec_op2_i = op2; dec_src_tag2_i = s2; dec_cmd_i = cmd;
  endtask

  task automatic do_reset();
    reset_i = 0;
    #1;
    for (int i = 0; i < NE; i++) m[i].busy = 1'b0;
    hold = -1;
    chk("rst_ready", 64'(ready_o), 64'h0);
    chk("rst_stall", 64'(stall_o), 64'h0);
    chk("rst_val1", rs_val1_o, 64'h0);
    chk("rst_val2", rs_val2_o, 64'h0);
    chk("rst_cmd", 64'(rs_cmd_o), 64'h0);
    chk("rst_tag", 64'(rs_tag_o), 64'h0);
    @(negedge clk_i);
    reset_i = 1;
  endtask

  initial begin
    hold = -1; seqc = 0;
    for (int i = 0; i < NE; i++) m[i].busy = 1'b0;
    idle();
    reset_i = 0;
    repeat (2) @(negedge clk_i);
    reset_i = 1;
    tick();

    // Ready operands issue the cycle after write.
    write(4'd3, {1'b1, 64'hA}, 4'd0, {1'b1, 64'hB}, 4'd0, 10'h2A);
    tick(); idle();
    chk("t2_ready", 64'(ready_o), 64'h1);
    chk("t2_val1", rs_val1_o, 64'hA);
    chk("t2_val2", rs_val2_o, 64'hB);
    chk("t2_tag", 64'(rs_tag_o), 64'h3);
    tick();

    // Memory broadcast wakes a waiting operand; exe bus ignored on memory access.
    write(4'd2, {1'b0, 64'h0}, 4'd5, {1'b1, 64'h1}, 4'd0, 10'h11);
    tick(); idle();
    chk("t3_wait", 64'(ready_o), 64'h0);
    mem_tag_i = 4'd5; mem_val_i = {1'b1, 64'hC0};
    tick(); idle();
    chk("t3_ready", 64'(ready_o), 64'h1);
    chk("t3_val1", rs_val1_o, 64'hC0);
    tick();
    write(4'd4, {1'b0, 64'h0}, 4'd5, {1'b1, 64'h2}, 4'd0, 10'h12);
    tick(); idle();
    exe_tag_i = 4'd5; exe_val_i = {1'b1, 64'hDD}; exe_mem_access_i = 1;
    tick(); tick();
    chk("t3_exe_ignored", 64'(ready_o), 64'h0);
    idle(); flush_i = 1;
    tick(); idle();

    // Same-cycle commit captured at write.
    write(4'd6, {1'b0, 64'h0}, 4'd7, {1'b1, 64'h3}, 4'd0, 10'h13);
    com_tag_i = 4'd7; com_val_i = {1'b1, 64'h77};
    tick(); idle();
    chk("t4_ready", 64'(ready_o), 64'h1);
    chk("t4_val1", rs_val1_o, 64'h77);
    tick();

    // Fill under downstream stall, then drain one per cycle in order.
    for (int k = 1; k <= NE; k++) begin
      write(4'(k), {1'b1, 64'(k * 16)}, 4'd0, {1'b1, 64'(k)}, 4'd0, 10'(k));
      stall_i = 1;
      tick();
    end
    idle(); stall_i = 1;
    chk("t5_full", 64'(stall_o), 64'h1);
    chk("t5_tag_hold", 64'(rs_tag_o), 64'h1);
    tick();
    chk("t5_tag_stable", 64'(rs_tag_o), 64'h1);
    chk("t5_val_stable", rs_val1_o, 64'h10);
    stall_i = 0;
    for (int k = 1; k <= NE; k++) begin
      chk("t5_order", 64'(rs_tag_o), 64'(k));
      tick();
    end
    chk("t5_empty", 64'(ready_o), 64'h0);

    // Asynchronous reset with three busy entries.
    for (int k = 1; k <= 3; k++) begin
      write(4'(k), {1'b1, 64'(k)}, 4'd0, {1'b1, 64'h5}, 4'd0, 10'h3);
      stall_i = 1;
      tick();
    end
    idle();
    do_reset();
    tick();

    // Flush beats a same-cycle write.
    write(4'd1, {1'b1, 64'h9}, 4'd0, {1'b1, 64'h9}, 4'd0, 10'h1);
    stall_i = 1;
    tick();
    flush_i = 1; stall_i = 0;
    write(4'd2, {1'b1, 64'h8}, 4'd0, {1'b1, 64'h8}, 4'd0, 10'h2);
    tick(); idle();
    chk("t6_ready", 64'(ready_o), 64'h0);
    chk("t6_stall", 64'(stall_o), 64'h0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      if (n == 200) do_reset();
      dec_we_i = ($urandom_range(0, 9) < 6);
      dec_tag_i = 4'($urandom_range(0, 8));
      dec_src_tag1_i = 4'($urandom_range(0, 8));
      dec_src_tag2_i = 4'($urandom_range(0, 8));
      dec_op1_i = {1'($urandom_range(0, 9) < 4), $urandom, $urandom};
      dec_op2_i = {1'($urandom_range(0, 9) < 4), $urandom, $urandom};
      dec_cmd_i = 10'($urandom);
      com_tag_i = 4'($urandom_range(0, 8));
      com_val_i = {1'($urandom_range(0, 1)), $urandom, $urandom};
      mem_tag_i = 4'($urandom_range(0, 8));
      mem_val_i = {1'($urandom_range(0, 1)), $urandom, $urandom};
      exe_tag_i = 4'($urandom_range(0, 8));
      exe_val_i = {1'($urandom_range(0, 1)), $urandom, $urandom};
      exe_mem_access_i = ($urandom_range(0, 3) == 0);
      stall_i = ($urandom_range(0, 9) < 3);
      flush_i = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
